cv32e40p_trace_buffer: RTL and testbench
========================================

Name: cv32e40p_trace_buffer

Overview:
Synthesizable, multi-channel successor to the simulation-only execution tracer.
- Captures retired-instruction events (pc, instr) from NUM_CH sources (harts or retire ports), timestamps them and stores them in a DEPTH-entry circular buffer.
- Buffer drains over a valid/ready port to a debug/trace sink.
- Never stalls the core. Three capture modes: free-running overwrite, stop-on-full, trigger with post-trigger count.

Parameters:
NUM_CH, 2, number of capture channels (>=1)
DEPTH, 16, buffer entries (power of two, >=2)
TS_W, 16, timestamp width
CH_W, $clog2(NUM_CH) min 1, channel-index width (derived)
CNT_W, $clog2(DEPTH)+1, level/post-count width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  capture enable
mode_i  in  2  0=FREE, 1=STOP, 2=TRIG, 3=reserved (behaves as STOP)
trigger_i  in  1  trigger pulse (TRIG mode)
post_count_i  in  CNT_W  entries to capture after trigger
clear_i  in  1  flush buffer and drop counter
ch_valid_i  in  NUM_CH  per-channel retire event
ch_pc_i  in  NUM_CH x 32  per-channel PC
ch_instr_i  in  NUM_CH x 32  per-channel instruction word
rd_valid_o  out  1  head entry available
rd_ready_i  in  1  sink accepts head
rd_pc_o  out  32  head PC
rd_instr_o  out  32  head instruction
rd_ch_o  out  CH_W  head source channel
rd_ts_o  out  TS_W  head timestamp
level_o  out  CNT_W  occupied entries
state_o  out  3  FSM state encoding
drop_cnt_o  out  16  lost-event counter, saturating

Behaviour:
- Reset: pointers 0, level_o=0, rd_valid_o=0, drop_cnt_o=0, timestamp=0, round-robin pointer 0, state IDLE. All read data outputs 0 while empty.
- Timestamp: free-running TS_W counter, +1 every cycle from reset, wraps to 0. Each entry stores the value from its write cycle.
- Arbitration: at most one write per cycle. Grant goes to the first valid channel at index >= rr, wrapping. After a grant, rr = (grant+1) mod NUM_CH.
- A write is stored in the same cycle. The entry is visible on rd_* the next cycle.
- FSM states: IDLE=0, RUN=1, ARMED=2, POST=3, DONE=4.
  - IDLE: capture off. Rising enable_i samples mode_i: TRIG -> ARMED, otherwise RUN.
  - RUN: capture. FREE overwrites when full; STOP drops when full.
  - ARMED: capture with overwrite. When trigger_i=1, the write in that cycle is stored. Latch post_count_i; if it is 0 go to DONE, otherwise go to POST.
  - POST: capture with overwrite. Each stored write decrements the latched count. The write that reaches 0 is stored, then go to DONE.
  - DONE: capture off. Stay until enable_i=0.
  - enable_i=0 in any state -> IDLE next cycle. Buffer contents are retained. trigger_i is ignored outside ARMED.
- Read: rd_valid_o = (level != 0). rd_* shows the head combinationally from storage. Pop when rd_valid_o & rd_ready_i.
- Simultaneous write and pop:
  - When full: normal push+pop, no loss.
  - When empty: write only; rd_valid_o rises next cycle.
- Overwrite (full, write, no pop, modes FREE/ARMED/POST): oldest entry discarded, both pointers advance, level stays DEPTH, drop +1. The head may change while rd_valid_o=1 and rd_ready_i=0; sinks must tolerate this in overwrite modes.
- Drop counter, saturating at 0xFFFF:
  - During capture states: +(valid channels - 1) per cycle for arbitration losers.
  - +1 per STOP full-drop.
  - +1 per overwrite.
  - Events in IDLE/DONE are not counted.
- clear_i: next cycle buffer is empty and drop_cnt_o=0. A write or pop in the same cycle is discarded. FSM state, timestamp and rr are unaffected. clear_i has priority over everything except rst_i.
- Reset mid-operation: all state returns to reset values on the next edge. Buffer data is not preserved.
- level_o counts 0..DEPTH inclusive. Pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Package cv32e40p_trace_pkg holds:
  - trace_mode_e (FREE/STOP/TRIG/RSVD).
  - trace_state_e (IDLE/RUN/ARMED/POST/DONE, 3-bit).
  - trace_entry_t struct {pc, instr, ch, ts}. Its ts field width comes from a package constant TRACE_TS_W (default 16), kept equal to the TS_W parameter.
- Sub-module cv32e40p_trace_rr_arbiter (NUM_CH): valid vector in; grant one-hot, grant index and loser count out; rr pointer kept internally.

Test Plan:
- FREE, NUM_CH=2, DEPTH=4: ch0 valid 6 cycles with pc 0x100..0x114, rd_ready_i=0. Then level_o=4, drop_cnt_o=2, and draining yields pc 0x108, 0x10C, 0x110, 0x114.
- STOP, DEPTH=4: 6 writes with no read -> level_o=4, drop_cnt_o=2, drained pcs are the first four. Full + write + pop in one cycle -> level stays 4, drop unchanged.
- Arbitration: ch0 and ch1 valid every cycle for 4 cycles -> entries alternate ch 0,1,0,1 and drop_cnt_o=4. Consecutive entries differ by 1 in rd_ts_o.
- TRIG: ARMED with a continuous stream, trigger_i at pc 0x200, post_count_i=2. Then state DONE, last three entries are pc 0x200, 0x204, 0x208, and no further writes occur.
- clear_i asserted while level_o=3 with a simultaneous write -> next cycle level_o=0, drop_cnt_o=0, rd_valid_o=0, state unchanged.
- rst_i asserted in POST with level_o=4 -> next cycle state IDLE, level 0, timestamp 0, all outputs 0.

Source files
------------

// File: rtl/cv32e40p_trace_pkg.sv
// Shared types for the multi-channel retire trace buffer: capture modes,
// FSM states and the stored entry layout.
package cv32e40p_trace_pkg;

  // Entry timestamp width; the buffer's TS_W parameter is expected to match.
  localparam int TRACE_TS_W = 16;
  localparam int TRACE_CH_W = 8;

  typedef enum logic [1:0] {
    MODE_FREE = 2'd0,
    MODE_STOP = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } trace_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } trace_state_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           instr;
    logic [TRACE_CH_W-1:0] ch;
    logic [TRACE_TS_W-1:0] ts;
  } trace_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [16:0] b);
    logic [17:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/cv32e40p_trace_rr_arbiter.sv
// Round-robin single-winner arbiter over retire channels; also reports how
// many valid channels lost this cycle.
module cv32e40p_trace_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int LW     = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
  input  logic [NUM_CH-1:0] valid_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   grant_idx_o,
  output logic              grant_valid_o,
  output logic [LW-1:0]     loser_cnt_o
);

  logic [CH_W-1:0] rr_q;
  logic [LW-1:0]   valid_cnt;

  always_comb begin
    int idx;
    idx           = 0;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    valid_cnt     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx       = (int'(rr_q) + k) % NUM_CH;
      valid_cnt = valid_cnt + LW'(valid_i[k]);
      if (!grant_valid_o && valid_i[CH_W'(idx)]) begin
        grant_valid_o         = 1'b1;
        grant_o[CH_W'(idx)]   = 1'b1;
        grant_idx_o           = CH_W'(idx);
      end
    end
    loser_cnt_o = grant_valid_o ? (valid_cnt - LW'(1)) : '0;
  end

  // Pointer only moves on grants that the buffer actually consumes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (advance_i && grant_valid_o) begin
      rr_q <= (grant_idx_o == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_o + CH_W'(1);
    end
  end

endmodule

// File: rtl/cv32e40p_trace_buffer.sv
// Timestamped circular trace buffer for retired instructions from several
// channels, with free-running, stop-on-full and triggered capture modes.
module cv32e40p_trace_buffer
  import cv32e40p_trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int TS_W   = TRACE_TS_W,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic                   trigger_i,
  input  logic [CNT_W-1:0]       post_count_i,
  input  logic                   clear_i,
  input  logic [NUM_CH-1:0]      ch_valid_i,
  input  logic [NUM_CH-1:0][31:0] ch_pc_i,
  input  logic [NUM_CH-1:0][31:0] ch_instr_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [31:0]            rd_pc_o,
  output logic [31:0]            rd_instr_o,
  output logic [CH_W-1:0]        rd_ch_o,
  output logic [TS_W-1:0]        rd_ts_o,
  output logic [CNT_W-1:0]       level_o,
  output logic [2:0]             state_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LW    = $clog2(NUM_CH + 1);

  trace_state_e     state_q, state_d;
  trace_mode_e      mode_q;
  logic [CNT_W-1:0] post_q;
  logic [CNT_W-1:0] level_q;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [TS_W-1:0]  ts_q;
  logic [15:0]      drop_q;
  trace_entry_t     mem [DEPTH];
  trace_entry_t     wr_entry, head;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_valid;
  logic [LW-1:0]     loser_cnt;

  logic capturing, overwrite_ok, full, empty, pop;
  logic wr_req, do_write, stored, ovf_drop, stop_drop, level_inc, level_dec;
  logic [16:0] drop_add;

  cv32e40p_trace_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .LW     (LW)
  ) u_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .advance_i     (capturing),
    .valid_i       (ch_valid_i),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .loser_cnt_o   (loser_cnt)
  );

  assign capturing    = (state_q == ST_RUN) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign overwrite_ok = (state_q != ST_RUN) || (mode_q == MODE_FREE);
  assign full         = (level_q == CNT_W'(DEPTH));
  assign empty        = (level_q == '0);
  assign pop          = !empty && rd_ready_i;
  assign wr_req       = capturing && grant_valid;
  assign ovf_drop     = wr_req && full && !pop && overwrite_ok;
  assign stop_drop    = wr_req && full && !pop && !overwrite_ok;
  assign do_write     = wr_req && !stop_drop;
  assign stored       = do_write && !clear_i;
  assign level_inc    = do_write && !pop && !full;
  assign level_dec    = pop && !do_write;
  assign drop_add     = capturing ? (17'(loser_cnt) + 17'(ovf_drop) + 17'(stop_drop)) : '0;

  always_comb begin
    wr_entry = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        wr_entry.pc    = ch_pc_i[k];
        wr_entry.instr = ch_instr_i[k];
      end
    end
    wr_entry.ch = TRACE_CH_W'(grant_idx);
    wr_entry.ts = TRACE_TS_W'(ts_q);
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = (trace_mode_e'(mode_i) == MODE_TRIG) ? ST_ARMED : ST_RUN;
        ST_ARMED: if (trigger_i) state_d = (post_count_i == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (stored && post_q == CNT_W'(1)) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // clear_i flushes occupancy and the drop counter but leaves FSM, timestamp and mode alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_FREE;
      post_q  <= '0;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (clear_i) begin
        level_q <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
        drop_q  <= '0;
      end else begin
        if (do_write)        wptr_q <= wptr_q + PTR_W'(1);
        if (pop || ovf_drop) rptr_q <= rptr_q + PTR_W'(1);
        if (level_inc)       level_q <= level_q + CNT_W'(1);
        else if (level_dec)  level_q <= level_q - CNT_W'(1);
        drop_q <= sat_add16(drop_q, drop_add);
      end
      if (state_q == ST_IDLE && enable_i) mode_q <= trace_mode_e'(mode_i);
      if (state_q == ST_ARMED && trigger_i)  post_q <= post_count_i;
      else if (state_q == ST_POST && stored) post_q <= post_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (stored) mem[wptr_q] <= wr_entry;
  end

  assign head       = mem[rptr_q];
  assign rd_valid_o = !empty;
  assign rd_pc_o    = rd_valid_o ? head.pc : '0;
  assign rd_instr_o = rd_valid_o ? head.instr : '0;
  assign rd_ch_o    = rd_valid_o ? CH_W'(head.ch) : '0;
  assign rd_ts_o    = rd_valid_o ? TS_W'(head.ts) : '0;
  assign level_o    = level_q;
  assign state_o    = state_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Directed scenario bench for cv32e40p_trace_buffer with NUM_CH=2, DEPTH=4.
module tb_cv32e40p_trace_buffer;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 16;
  localparam int CH_W   = 1;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_i, enable_i, trigger_i, clear_i, rd_ready_i;
  logic [1:0]               mode_i;
  logic [CNT_W-1:0]         post_count_i;
  logic [NUM_CH-1:0]        ch_valid_i;
  logic [NUM_CH-1:0][31:0]  ch_pc_i, ch_instr_i;
  logic                     rd_valid_o;
  logic [31:0]              rd_pc_o, rd_instr_o;
  logic [CH_W-1:0]          rd_ch_o;
  logic [TS_W-1:0]          rd_ts_o;
  logic [CNT_W-1:0]         level_o;
  logic [2:0]               state_o;
  logic [15:0]              drop_cnt_o;

  int checks = 0;
  int passed = 0;

  cv32e40p_trace_buffer #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .trigger_i    (trigger_i),
    .post_count_i (post_count_i),
    .clear_i      (clear_i),
    .ch_valid_i   (ch_valid_i),
    .ch_pc_i      (ch_pc_i),
    .ch_instr_i   (ch_instr_i),
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready_i),
    .rd_pc_o      (rd_pc_o),
    .rd_instr_o   (rd_instr_o),
    .rd_ch_o      (rd_ch_o),
    .rd_ts_o      (rd_ts_o),
    .level_o      (level_o),
    .state_o      (state_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trigger_i    = 1'b0;
    clear_i      = 1'b0;
    rd_ready_i   = 1'b0;
    post_count_i = '0;
    ch_valid_i   = '0;
    ch_pc_i      = '0;
    ch_instr_i   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    enable_i = 1'b0;
    mode_i   = 2'd0;
    rst_i    = 1'b1;
    tick();
    rst_i    = 1'b0;
  endtask

  task automatic start(input logic [1:0] m);
    mode_i   = m;
    enable_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level_o !== 3'd0) $display("[TB] FAIL reset_level: got %0d, expected 0", level_o); else passed++;
    checks++; if (rd_valid_o !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %0b, expected 0", rd_valid_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd0) $display("[TB] FAIL reset_drop: got %0d, expected 0", drop_cnt_o); else passed++;
    checks++; if (state_o !== 3'd0) $display("[TB] FAIL reset_state: got %0d, expected 0", state_o); else passed++;
    checks++; if (rd_pc_o !== 32'd0) $display("[TB] FAIL reset_rd_pc: got %h, expected 0", rd_pc_o); else passed++;
  endtask

  task automatic test_free();
    do_reset();
    start(2'd0);
    checks++; if (state_o !== 3'd1) $display("[TB] FAIL free_state_run: got %0d, expected 1", state_o); else passed++;
    for (int i = 0; i < 6; i++) begin
      ch_valid_i    = 2'b01;
      ch_pc_i[0]    = 32'h100 + 32'(4 * i);
      ch_instr_i[0] = 32'h1000 + 32'(i);
      tick();
    end
    ch_valid_i = '0;
    checks++; if (level_o !== 3'd4) $display("[TB] FAIL free_level: got %0d, expected 4", level_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd2) $display("[TB] FAIL free_drop: got %0d, expected 2", drop_cnt_o); else passed++;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_pc_o !== 32'h108 + 32'(4 * i)) $display("[TB] FAIL free_drain_pc%0d: got %h, expected %h", i, rd_pc_o, 32'h108 + 32'(4 * i)); else passed++;
      checks++; if (rd_instr_o !== 32'h1002 + 32'(i)) $display("[TB] FAIL free_drain_instr%0d: got %h, expected %h", i, rd_instr_o, 32'h1002 + 32'(i)); else passed++;
      tick();
    end
    rd_ready_i = 1'b0;
    checks++; if (rd_valid_o !== 1'b0) $display("[TB] FAIL free_empty_valid: got %0b, expected 0", rd_valid_o); else passed++;
    checks++; if (level_o !== 3'd0) $display("[TB] FAIL free_empty_level: got %0d, expected 0", level_o); else passed++;
  endtask

  task automatic test_stop();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h304; exp_pc[1] = 32'h308; exp_pc[2] = 32'h30C; exp_pc[3] = 32'h400;
    do_reset();
    start(2'd1);
    for (int i = 0; i < 6; i++) begin
      ch_valid_i = 2'b01;
      ch_pc_i[0] = 32'h300 + 32'(4 * i);
      tick();
    end
    ch_valid_i = '0;
    checks++; if (level_o !== 3'd4) $display("[TB] FAIL stop_level: got %0d, expected 4", level_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd2) $display("[TB] FAIL stop_drop: got %0d, expected 2", drop_cnt_o); else passed++;
    checks++; if (rd_pc_o !== 32'h300) $display("[TB] FAIL stop_head: got %h, expected 300", rd_pc_o); else passed++;
    ch_valid_i = 2'b01;
    ch_pc_i[0] = 32'h400;
    rd_ready_i = 1'b1;
    tick();
    ch_valid_i = '0;
    checks++; if (level_o !== 3'd4) $display("[TB] FAIL stop_pushpop_level: got %0d, expected 4", level_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd2) $display("[TB] FAIL stop_pushpop_drop: got %0d, expected 2", drop_cnt_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_pc_o !== exp_pc[i]) $display("[TB] FAIL stop_drain_pc%0d: got %h, expected %h", i, rd_pc_o, exp_pc[i]); else passed++;
      tick();
    end
    rd_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h500; exp_pc[1] = 32'h610; exp_pc[2] = 32'h520; exp_pc[3] = 32'h630;
    do_reset();
    start(2'd0);
    for (int i = 0; i < 4; i++) begin
      ch_valid_i = 2'b11;
      ch_pc_i[0] = 32'h500 + 32'(16 * i);
      ch_pc_i[1] = 32'h600 + 32'(16 * i);
      tick();
    end
    ch_valid_i = '0;
    checks++; if (level_o !== 3'd4) $display("[TB] FAIL arb_level: got %0d, expected 4", level_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd4) $display("[TB] FAIL arb_drop: got %0d, expected 4", drop_cnt_o); else passed++;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_ch_o !== CH_W'(i % 2)) $display("[TB] FAIL arb_ch%0d: got %0d, expected %0d", i, rd_ch_o, i % 2); else passed++;
      checks++; if (rd_pc_o !== exp_pc[i]) $display("[TB] FAIL arb_pc%0d: got %h, expected %h", i, rd_pc_o, exp_pc[i]); else passed++;
      checks++; if (rd_ts_o !== 16'(1 + i)) $display("[TB] FAIL arb_ts%0d: got %0d, expected %0d", i, rd_ts_o, 1 + i); else passed++;
      tick();
    end
    rd_ready_i = 1'b0;
  endtask

  task automatic test_trig();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h1FC; exp_pc[1] = 32'h200; exp_pc[2] = 32'h204; exp_pc[3] = 32'h208;
    do_reset();
    start(2'd2);
    checks++; if (state_o !== 3'd2) $display("[TB] FAIL trig_armed: got %0d, expected 2", state_o); else passed++;
    post_count_i = 3'd2;
    for (int i = 0; i < 10; i++) begin
      ch_valid_i = 2'b01;
      ch_pc_i[0] = 32'h1F0 + 32'(4 * i);
      trigger_i  = (i == 4);
      tick();
      if (i == 4) begin
        checks++; if (state_o !== 3'd3) $display("[TB] FAIL trig_post: got %0d, expected 3", state_o); else passed++;
      end
    end
    ch_valid_i = '0;
    trigger_i  = 1'b0;
    checks++; if (state_o !== 3'd4) $display("[TB] FAIL trig_done: got %0d, expected 4", state_o); else passed++;
    checks++; if (level_o !== 3'd4) $display("[TB] FAIL trig_level: got %0d, expected 4", level_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd3) $display("[TB] FAIL trig_drop: got %0d, expected 3", drop_cnt_o); else passed++;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_pc_o !== exp_pc[i]) $display("[TB] FAIL trig_drain_pc%0d: got %h, expected %h", i, rd_pc_o, exp_pc[i]); else passed++;
      tick();
    end
    rd_ready_i = 1'b0;
    enable_i   = 1'b0;
    tick();
    checks++; if (state_o !== 3'd0) $display("[TB] FAIL trig_disable_idle: got %0d, expected 0", state_o); else passed++;
  endtask

  task automatic test_clear();
    do_reset();
    start(2'd0);
    ch_valid_i = 2'b11; ch_pc_i[0] = 32'h700; ch_pc_i[1] = 32'h7F0; tick();
    ch_valid_i = 2'b01; ch_pc_i[0] = 32'h704; tick();
    ch_pc_i[0] = 32'h708; tick();
    checks++; if (level_o !== 3'd3) $display("[TB] FAIL clear_pre_level: got %0d, expected 3", level_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd1) $display("[TB] FAIL clear_pre_drop: got %0d, expected 1", drop_cnt_o); else passed++;
    clear_i    = 1'b1;
    ch_pc_i[0] = 32'h70C;
    rd_ready_i = 1'b1;
    tick();
    idle_inputs();
    checks++; if (level_o !== 3'd0) $display("[TB] FAIL clear_level: got %0d, expected 0", level_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd0) $display("[TB] FAIL clear_drop: got %0d, expected 0", drop_cnt_o); else passed++;
    checks++; if (rd_valid_o !== 1'b0) $display("[TB] FAIL clear_rd_valid: got %0b, expected 0", rd_valid_o); else passed++;
    checks++; if (state_o !== 3'd1) $display("[TB] FAIL clear_state: got %0d, expected 1", state_o); else passed++;
    ch_valid_i = 2'b01; ch_pc_i[0] = 32'h710; tick();
    ch_valid_i = '0;
    checks++; if (level_o !== 3'd1) $display("[TB] FAIL clear_after_level: got %0d, expected 1", level_o); else passed++;
    checks++; if (rd_pc_o !== 32'h710) $display("[TB] FAIL clear_after_pc: got %h, expected 710", rd_pc_o); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    start(2'd2);
    post_count_i = 3'd3;
    for (int i = 0; i < 4; i++) begin
      ch_valid_i    = 2'b01;
      ch_pc_i[0]    = 32'h800 + 32'(4 * i);
      ch_instr_i[0] = 32'hABC0 + 32'(i);
      trigger_i     = (i == 3);
      tick();
    end
    trigger_i = 1'b0;
    checks++; if (state_o !== 3'd3) $display("[TB] FAIL rstmid_pre_state: got %0d, expected 3", state_o); else passed++;
    checks++; if (level_o !== 3'd4) $display("[TB] FAIL rstmid_pre_level: got %0d, expected 4", level_o); else passed++;
    rst_i = 1'b1;
    tick();
    rst_i      = 1'b0;
    ch_valid_i = '0;
    checks++; if (state_o !== 3'd0) $display("[TB] FAIL rstmid_state: got %0d, expected 0", state_o); else passed++;
    checks++; if (level_o !== 3'd0) $display("[TB] FAIL rstmid_level: got %0d, expected 0", level_o); else passed++;
    checks++; if (rd_valid_o !== 1'b0) $display("[TB] FAIL rstmid_rd_valid: got %0b, expected 0", rd_valid_o); else passed++;
    checks++; if (drop_cnt_o !== 16'd0) $display("[TB] FAIL rstmid_drop: got %0d, expected 0", drop_cnt_o); else passed++;
    checks++; if ({rd_pc_o, rd_instr_o, rd_ts_o, rd_ch_o} !== '0) $display("[TB] FAIL rstmid_rd_data: got %h %h %h %h, expected all 0", rd_pc_o, rd_instr_o, rd_ts_o, rd_ch_o); else passed++;
    tick();
    checks++; if (state_o !== 3'd2) $display("[TB] FAIL rstmid_rearm: got %0d, expected 2", state_o); else passed++;
    ch_valid_i = 2'b01; ch_pc_i[0] = 32'h900; tick();
    ch_valid_i = '0;
    checks++; if (rd_pc_o !== 32'h900) $display("[TB] FAIL rstmid_new_pc: got %h, expected 900", rd_pc_o); else passed++;
    checks++; if (rd_ts_o !== 16'd1) $display("[TB] FAIL rstmid_new_ts: got %0d, expected 1", rd_ts_o); else passed++;
  endtask

  initial begin
    rst_i    = 1'b1;
    enable_i = 1'b0;
    mode_i   = 2'd0;
    idle_inputs();
    test_reset();
    test_free();
    test_stop();
    test_back_to_back();
    test_trig();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
